max7219_chain_ctrl: RTL and testbench

//  Sequencer for a daisy chain of N_DEV MAX7219 8x8 LED drivers. After reset it sends the

---
 rtl/max7219_pkg.sv | 54 +++++
 rtl/max7219_chain_shifter.sv | 121 ++++++++++++
 rtl/max7219_chain_ctrl.sv | 159 +++++++++++++++
 tb/tb_max7219_chain_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - MAX7219 register map, FSM encodings and word builders
package max7219_pkg;

    localparam logic [3:0] REG_NOOP     = 4'h0;
    localparam logic [3:0] REG_DIGIT0   = 4'h1;
    localparam logic [3:0] REG_DECODE   = 4'h9;
    localparam logic [3:0] REG_INTENS   = 4'hA;
    localparam logic [3:0] REG_SCANLIM  = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN = 4'hC;
    localparam logic [3:0] REG_TEST     = 4'hF;

    localparam logic [2:0] INIT_LAST       = 3'd4;
    localparam logic [2:0] INIT_INTENS_IDX = 3'd3;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_INT_UPD,
        ST_FRAME
    } ctrl_state_e;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_HIGH,
        PH_LOW,
        PH_GAP
    } shift_phase_e;

    function automatic logic [15:0] build_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

    function automatic logic [3:0] init_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    return REG_SHUTDOWN;
            3'd1:    return REG_DECODE;
            3'd2:    return REG_SCANLIM;
            3'd3:    return REG_INTENS;
            3'd4:    return REG_TEST;
            default: return REG_NOOP;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [2:0] idx, input logic [3:0] intens);
        case (idx)
            3'd0:    return 8'h01;
            3'd2:    return 8'h07;
            3'd3:    return {4'h0, intens};
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/max7219_chain_shifter.sv
// rtl/max7219_chain_shifter.sv - shifts one chain-wide word out on sck/dout with cs framing
module max7219_chain_shifter import max7219_pkg::*; #(
    parameter int N_DEV   = 2,
    parameter int CLK_DIV = 5,
    parameter int CS_GAP  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [N_DEV*16-1:0]   word_i,
    output logic                  ready_o,
    output logic                  sck_o,
    output logic                  dout_o,
    output logic                  cs_o,
    output logic                  done_o
);

    localparam int W  = N_DEV * 16;
    localparam int BW = $clog2(W);
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(CS_GAP + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP);

    shift_phase_e    phase_q, phase_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [W-1:0]    sr_q, sr_d;
    logic            sck_q, sck_d;
    logic            cs_q, cs_d;
    logic            done_q, done_d;
    logic            half_end;

    assign half_end = (div_q == DIV_LAST);
    // A new load is accepted on the last gap cycle so back-to-back words keep the exact period.
    assign ready_o  = (phase_q == PH_IDLE) || (phase_q == PH_GAP && half_end && gap_q == GAP_LAST);
    assign sck_o    = sck_q;
    assign cs_o     = cs_q;
    assign dout_o   = sr_q[W-1];
    assign done_o   = done_q;

    always_comb begin
        phase_d = phase_q;
        div_d   = (phase_q == PH_IDLE || half_end) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        done_d  = 1'b0;

        if (half_end) begin
            unique case (phase_q)
                PH_SETUP: begin
                    sck_d   = 1'b1;
                    phase_d = PH_HIGH;
                end
                PH_HIGH: begin
                    sck_d   = 1'b0;
                    sr_d    = {sr_q[W-2:0], 1'b0};
                    phase_d = PH_LOW;
                end
                PH_LOW: begin
                    if (bit_q == LAST_BIT) begin
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        gap_d   = '0;
                        phase_d = PH_GAP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sck_d   = 1'b1;
                        phase_d = PH_HIGH;
                    end
                end
                PH_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        phase_d = PH_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (ready_o && load_i) begin
            sr_d    = word_i;
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            bit_d   = '0;
            div_d   = '0;
            phase_d = PH_SETUP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= PH_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sr_q    <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sr_q    <= sr_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/max7219_chain_ctrl.sv
// rtl/max7219_chain_ctrl.sv - MAX7219 chain sequencer: init, intensity updates and frame refresh
module max7219_chain_ctrl import max7219_pkg::*; #(
    parameter int N_DEV   = 2,
    parameter int CLK_DIV = 5,
    parameter int CS_GAP  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_DEV*64-1:0]   pixels_i,
    input  logic                  frame_valid_i,
    output logic                  frame_ready_o,
    input  logic [3:0]            intensity_i,
    output logic                  sck_o,
    output logic                  dout_o,
    output logic                  cs_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    ctrl_state_e            state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             row_q, row_d;
    logic                   issued_q, issued_d;
    logic [3:0]             int_sent_q, int_sent_d;
    logic [N_DEV*64-1:0]    buf_q, buf_d;

    logic                   sh_load, sh_ready, sh_done;
    logic [2:0]             sel;
    logic [N_DEV*16-1:0]    word;

    max7219_chain_shifter #(
        .N_DEV   (N_DEV),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_shifter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (sh_load),
        .word_i  (word),
        .ready_o (sh_ready),
        .sck_o   (sck_o),
        .dout_o  (dout_o),
        .cs_o    (cs_o),
        .done_o  (sh_done)
    );

    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = sh_done && (state_q == ST_FRAME) && (row_q == 3'd7);

    // issued_q marks that the current step's word is on the wire; the next shifter
    // ready then means that word has finished, including its cs gap.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_d         = row_q;
        issued_d      = issued_q;
        int_sent_d    = int_sent_q;
        buf_d         = buf_q;
        sh_load       = 1'b0;
        frame_ready_o = 1'b0;
        sel           = (state_q == ST_FRAME) ? row_q : idx_q;

        unique case (state_q)
            ST_INIT: begin
                if (sh_ready) begin
                    if (!issued_q) begin
                        sh_load  = 1'b1;
                        issued_d = 1'b1;
                    end else if (idx_q == INIT_LAST) begin
                        state_d  = ST_IDLE;
                        issued_d = 1'b0;
                    end else begin
                        sel     = idx_q + 3'd1;
                        idx_d   = sel;
                        sh_load = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                frame_ready_o = (intensity_i == int_sent_q);
                if (intensity_i != int_sent_q) begin
                    state_d  = ST_INT_UPD;
                    issued_d = 1'b0;
                end else if (frame_valid_i) begin
                    buf_d    = pixels_i;
                    row_d    = 3'd0;
                    state_d  = ST_FRAME;
                    issued_d = 1'b0;
                end
            end
            ST_INT_UPD: begin
                if (sh_ready) begin
                    if (!issued_q) begin
                        sh_load  = 1'b1;
                        issued_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        issued_d = 1'b0;
                    end
                end
            end
            ST_FRAME: begin
                if (sh_ready) begin
                    if (!issued_q) begin
                        sh_load  = 1'b1;
                        issued_d = 1'b1;
                    end else if (row_q == 3'd7) begin
                        state_d  = ST_IDLE;
                        issued_d = 1'b0;
                    end else begin
                        sel     = row_q + 3'd1;
                        row_d   = sel;
                        sh_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (sh_load && (state_q == ST_INT_UPD ||
                        (state_q == ST_INIT && sel == INIT_INTENS_IDX))) begin
            int_sent_d = intensity_i;
        end
    end

    // Word n*16 of the stream lands in device n, so device N_DEV-1 sits in the top slice.
    always_comb begin
        word = '0;
        for (int d = 0; d < N_DEV; d++) begin
            if (state_q == ST_FRAME) begin
                word[d*16 +: 16] = build_word(REG_DIGIT0 + {1'b0, sel},
                                              buf_q[d*64 + int'(sel)*8 +: 8]);
            end else if (state_q == ST_INT_UPD) begin
                word[d*16 +: 16] = build_word(REG_INTENS, {4'h0, intensity_i});
            end else begin
                word[d*16 +: 16] = build_word(init_addr(sel), init_data(sel, intensity_i));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            idx_q      <= '0;
            row_q      <= '0;
            issued_q   <= 1'b0;
            int_sent_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            issued_q   <= issued_d;
            int_sent_q <= int_sent_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// tb/tb_max7219_chain_ctrl.sv - scoreboard bench with a behavioural MAX7219 chain model
module tb_max7219_chain_ctrl;

    localparam int N_DEV   = 2;
    localparam int CLK_DIV = 5;
    localparam int CS_GAP  = 2;
    localparam int W       = N_DEV * 16;
    localparam int T_XACT  = (2 * N_DEV * 16 + 2 + CS_GAP) * CLK_DIV;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_DEV*64-1:0] pixels = '0;
    logic                frame_valid = 1'b0;
    logic                frame_ready;
    logic [3:0]          intensity = 4'h8;
    logic                sck, dout, cs, busy, frame_done;

    max7219_chain_ctrl #(.N_DEV(N_DEV), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pixels_i      (pixels),
        .frame_valid_i (frame_valid),
        .frame_ready_o (frame_ready),
        .intensity_i   (intensity),
        .sck_o         (sck),
        .dout_o        (dout),
        .cs_o          (cs),
        .busy_o        (busy),
        .frame_done_o  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] exp_q[$];
    int           fall_cyc[$];
    int           cyc = 0;
    int           latch_cnt = 0, partial_cnt = 0, cap_cnt = 0, viol_cnt = 0, done_cnt = 0;
    int           run_len = 0, t_err = 0, nbits = 0;
    logic         prev_sck = 1'b0, prev_cs = 1'b1, prev_dout = 1'b0;
    logic [W-1:0] chain = '0;
    logic [7:0]   mreg [N_DEV][16];

    initial begin
        for (int d = 0; d < N_DEV; d++)
            for (int a = 0; a < 16; a++) mreg[d][a] = 8'h00;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: shift on sck rise while cs low, latch all devices on cs rise.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (frame_ready && frame_valid) cap_cnt++;
        if (frame_ready && busy) viol_cnt++;
        if (frame_done) done_cnt++;
        if (sck != prev_sck || cs != prev_cs) begin
            if (!prev_cs && run_len != CLK_DIV) t_err++;
            run_len = 1;
        end else begin
            run_len++;
        end
        if (prev_cs && !cs) begin
            fall_cyc.push_back(cyc);
            nbits = 0;
            t_err = 0;
        end
        if (!cs && sck && !prev_sck) begin
            if (dout != prev_dout) t_err++;
            chain = {chain[W-2:0], dout};
            nbits++;
        end
        if (!prev_cs && cs) begin
            if (nbits == W) begin
                check("timing", t_err, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", chain, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", chain, e);
                end
                for (int d = 0; d < N_DEV; d++) mreg[d][chain[d*16+8 +: 4]] = chain[d*16 +: 8];
                latch_cnt++;
            end else begin
                partial_cnt++;
            end
        end
        prev_sck  = sck;
        prev_cs   = cs;
        prev_dout = dout;
    end

    function automatic logic [W-1:0] bcast(input logic [3:0] a, input logic [7:0] d);
        return {N_DEV{{4'h0, a, d}}};
    endfunction

    function automatic logic [W-1:0] row_word(input logic [127:0] px, input int r);
        logic [7:0] d1, d0;
        d1 = px[64 + r*8 +: 8];
        d0 = px[r*8 +: 8];
        return {4'h0, 4'(r + 1), d1, 4'h0, 4'(r + 1), d0};
    endfunction

    task automatic push_init(input logic [3:0] intens);
        exp_q.push_back(bcast(4'hC, 8'h01));
        exp_q.push_back(bcast(4'h9, 8'h00));
        exp_q.push_back(bcast(4'hB, 8'h07));
        exp_q.push_back(bcast(4'hA, {4'h0, intens}));
        exp_q.push_back(bcast(4'hF, 8'h00));
    endtask

    task automatic push_frame(input logic [127:0] px);
        for (int r = 0; r < 8; r++) exp_q.push_back(row_word(px, r));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic send_frame(input logic [127:0] px, input bit drop, input int budget);
        int n = 0;
        pixels      = px;
        frame_valid = 1'b1;
        @(negedge clk);
        while (!frame_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("capture_timeout", frame_ready, 1);
        @(posedge clk);
        #1;
        if (drop) frame_valid = 1'b0;
    endtask

    logic [127:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_g;
    int           base;

    initial begin
        pat_a = {64'h0102040810204080, 64'hFFFFFFFFFFFFFFFF};
        pat_b = 128'h00112233445566778899AABBCCDDEEFF;
        pat_c = 128'hF0E1D2C3B4A596877869584A3B2C1D0E;
        pat_d = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
        pat_e = 128'h5A5A5A5AA5A5A5A53C3CC3C30FF0F00F;
        pat_g = 128'hA1A2A3A4A5A6A7A8B1B2B3B4B5B6B7B8;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sck", sck, 0);
        check("rst_dout", dout, 0);
        check("rst_cs", cs, 1);
        check("rst_busy", busy, 1);
        check("rst_ready", frame_ready, 0);
        check("rst_done", frame_done, 0);

        // Init sequence and back-to-back transaction period
        push_init(4'h8);
        fall_cyc.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(5 * T_XACT + 100);
        check("init_falls", fall_cyc.size(), 5);
        for (int i = 0; i + 1 < fall_cyc.size(); i++)
            check("xact_period", fall_cyc[i+1] - fall_cyc[i], T_XACT);
        check("init_q_empty", exp_q.size(), 0);
        check("init_ready", frame_ready, 1);
        check("init_intens_d0", mreg[0][10], 8'h08);
        check("init_scanlim_d1", mreg[1][11], 8'h07);
        check("init_shutdown_d1", mreg[1][12], 8'h01);

        // Single frame, valid held until capture
        base = cap_cnt;
        push_frame(pat_a);
        @(posedge clk);
        #1;
        base = done_cnt;
        send_frame(pat_a, 1'b1, 100);
        @(negedge clk);
        check("after_cap_ready", frame_ready, 0);
        check("after_cap_busy", busy, 1);
        wait_idle(8 * T_XACT + 100);
        check("frame_done_cnt", done_cnt - base, 1);
        check("d1_digit1", mreg[1][1], 8'h80);
        check("d1_digit8", mreg[1][8], 8'h01);
        check("d0_digit5", mreg[0][5], 8'hFF);
        check("frame_q_empty", exp_q.size(), 0);

        // Intensity change during a frame, with a second frame pending
        push_frame(pat_b);
        @(posedge clk);
        #1;
        send_frame(pat_b, 1'b1, 100);
        repeat (300) @(posedge clk);
        #1 intensity = 4'h3;
        exp_q.push_back(bcast(4'hA, 8'h03));
        push_frame(pat_c);
        send_frame(pat_c, 1'b1, 10 * T_XACT);
        wait_idle(8 * T_XACT + 100);
        check("int_upd_d0", mreg[0][10], 8'h03);
        check("int_upd_d1", mreg[1][10], 8'h03);
        check("int_q_empty", exp_q.size(), 0);

        // Back-to-back frames with pixels changing right after capture
        base = cap_cnt;
        viol_cnt = 0;
        push_frame(pat_d);
        push_frame(pat_e);
        @(posedge clk);
        #1;
        send_frame(pat_d, 1'b0, 100);
        send_frame(pat_e, 1'b1, 10 * T_XACT);
        pixels = ~pat_e;
        wait_idle(8 * T_XACT + 100);
        check("b2b_captures", cap_cnt - base, 2);
        check("ready_while_busy", viol_cnt, 0);
        check("b2b_q_empty", exp_q.size(), 0);

        // Reset in the middle of the row-3 transaction
        base = latch_cnt;
        push_frame(pat_g);
        @(posedge clk);
        #1;
        send_frame(pat_g, 1'b1, 100);
        for (int n = 0; n < 4 * T_XACT && latch_cnt < base + 3; n++) @(negedge clk);
        check("rows_before_abort", latch_cnt - base, 3);
        for (int n = 0; n < 100 && cs; n++) @(negedge clk);
        check("row3_started", cs, 0);
        repeat (47) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_cs", cs, 1);
        check("abort_sck", sck, 0);
        check("abort_busy", busy, 1);
        exp_q.delete();
        push_init(4'h3);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(5 * T_XACT + 100);
        check("abort_partial", partial_cnt, 1);
        check("abort_q_empty", exp_q.size(), 0);
        check("kept_row3_d1", mreg[1][4], pat_e[64+24 +: 8]);
        check("kept_row3_d0", mreg[0][4], pat_e[24 +: 8]);
        check("new_row0_d1", mreg[1][1], pat_g[64 +: 8]);
        check("reinit_intens", mreg[1][10], 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
